// File: rtl/dpram_arb_2048x16_pkg.sv
// dpram_arb_2048x16_pkg: shared defaults and FSM encoding for the SDRAM cache-RAM port-A scheduler
package dpram_arb_2048x16_pkg;
    localparam int RAM_AW = 11;
    localparam int RAM_DW = 16;
    localparam int RAM_BW = RAM_DW / 8;
    localparam int FILL_BURST = 4;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CPU  = 2'd1,
        ST_FILL = 2'd2
    } state_t;
endpackage

// File: rtl/dpram_arb_2048x16_rr_arb2.sv
// dpram_arb_2048x16_rr_arb2: two-way round-robin arbiter, grants only while enabled
module dpram_arb_2048x16_rr_arb2 (
    input  logic       clock,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    logic last;  // 1: req[1] was granted most recently, so req[0] wins the next tie
    assign gnt[0] = en && req[0] && (!req[1] || last);
    assign gnt[1] = en && req[1] && (!req[0] || !last);
    always_ff @(posedge clock) begin
        if (reset) last <= 1'b1;
        else if (|gnt) last <= gnt[1];
    end
endmodule

// File: rtl/dpram_arb_2048x16.sv
// dpram_arb_2048x16: port-A scheduler sharing the cache RAM between CPU word accesses and SDRAM line fills
module dpram_arb_2048x16 import dpram_arb_2048x16_pkg::*; #(
    parameter int AW    = RAM_AW,
    parameter int DW    = RAM_DW,
    parameter int BW    = RAM_BW,
    parameter int BURST = FILL_BURST
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [BW-1:0] cpu_be,
    input  logic [AW-1:0] cpu_adr,
    input  logic [DW-1:0] cpu_dat_w,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_dat_r,
    output logic          cpu_rvalid,
    input  logic          fill_req,
    input  logic [AW-1:0] fill_adr,
    input  logic          fill_dv,
    input  logic [DW-1:0] fill_dat,
    output logic          fill_grant,
    output logic          fill_done,
    output logic          ram_wren,
    output logic [BW-1:0] ram_byteena,
    output logic [AW-1:0] ram_address,
    output logic [DW-1:0] ram_data,
    input  logic [DW-1:0] ram_q
);
    localparam int CW = $clog2(BURST);
    state_t state, state_nx;
    logic [1:0] gnt;
    logic [CW-1:0] cnt;
    logic [AW-CW-1:0] base;
    logic fill_wr, last_word, rd_issue, rd_pend;
    logic unused_adr_lsbs;
    assign unused_adr_lsbs = ^fill_adr[CW-1:0];
    dpram_arb_2048x16_rr_arb2 u_rr_arb2 (
        .clock(clock),
        .reset(reset),
        .en   (state == ST_IDLE),
        .req  ({fill_req, cpu_req}),
        .gnt  (gnt)
    );
    assign fill_wr    = state == ST_FILL && fill_dv;
    assign last_word  = cnt == CW'(BURST - 1);
    assign cpu_ack    = state == ST_CPU;
    assign fill_grant = state == ST_FILL;
    always_comb begin
        state_nx = ST_IDLE;
        case (state)
            ST_IDLE: state_nx = gnt[0] ? ST_CPU : gnt[1] ? ST_FILL : ST_IDLE;
            ST_FILL: state_nx = fill_wr && last_word ? ST_IDLE : ST_FILL;
            default: state_nx = ST_IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            base        <= '0;
            ram_wren    <= 1'b0;
            ram_byteena <= '0;
            ram_address <= '0;
            ram_data    <= '0;
            fill_done   <= 1'b0;
            rd_issue    <= 1'b0;
            rd_pend     <= 1'b0;
            cpu_rvalid  <= 1'b0;
            cpu_dat_r   <= '0;
        end else begin
            state      <= state_nx;
            ram_wren   <= 1'b0;
            fill_done  <= fill_wr && last_word;
            // read return: RAM samples at the end of CPU, q valid one cycle later, captured the next
            rd_issue   <= gnt[0] && !cpu_we;
            rd_pend    <= rd_issue;
            cpu_rvalid <= rd_pend;
            if (rd_pend) cpu_dat_r <= ram_q;
            if (gnt[1]) base <= fill_adr[AW-1:CW];
            if (gnt[0]) begin
                ram_address <= cpu_adr;
                ram_wren    <= cpu_we;
                ram_byteena <= cpu_we ? cpu_be : '0;
                ram_data    <= cpu_dat_w;
            end else if (fill_wr) begin
                ram_address <= {base, cnt};
                ram_wren    <= 1'b1;
                ram_byteena <= '1;
                ram_data    <= fill_dat;
                cnt         <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_dpram_arb_2048x16.sv
// tb_dpram_arb_2048x16: directed plus random traffic against a word-level memory model and read-return queue
module tb_dpram_arb_2048x16;
    localparam int AW = 11, DW = 16, BW = 2, BURST = 4;
    logic clock = 1'b0, reset = 1'b1;
    logic cpu_req = 1'b0, cpu_we = 1'b0;
    logic [BW-1:0] cpu_be = '0;
    logic [AW-1:0] cpu_adr = '0;
    logic [DW-1:0] cpu_dat_w = '0;
    logic cpu_ack, cpu_rvalid;
    logic [DW-1:0] cpu_dat_r;
    logic fill_req = 1'b0, fill_dv = 1'b0;
    logic [AW-1:0] fill_adr = '0;
    logic [DW-1:0] fill_dat = '0;
    logic fill_grant, fill_done, ram_wren;
    logic [BW-1:0] ram_byteena;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_data, ram_q;
    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] ref_mem [2**AW];
    typedef struct {int cyc; logic [DW-1:0] dat;} rd_t;
    rd_t rq[$];
    int cyc = 0, n_cmp = 0, n_bad = 0;

    always #5 clock = ~clock;

    dpram_arb_2048x16 dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_adr(cpu_adr),
        .cpu_dat_w(cpu_dat_w), .cpu_ack(cpu_ack), .cpu_dat_r(cpu_dat_r), .cpu_rvalid(cpu_rvalid),
        .fill_req(fill_req), .fill_adr(fill_adr), .fill_dv(fill_dv), .fill_dat(fill_dat),
        .fill_grant(fill_grant), .fill_done(fill_done),
        .ram_wren(ram_wren), .ram_byteena(ram_byteena), .ram_address(ram_address),
        .ram_data(ram_data), .ram_q(ram_q)
    );

    // byte-enable RAM with registered read, read-before-write
    always @(posedge clock) begin
        logic [DW-1:0] w;
        ram_q <= mem[ram_address];
        w = mem[ram_address];
        if (ram_byteena[0]) w[7:0] = ram_data[7:0];
        if (ram_byteena[1]) w[15:8] = ram_data[15:8];
        if (ram_wren) mem[ram_address] = w;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
        cyc++;
        if (rq.size() > 0 && rq[0].cyc == cyc) begin
            chk("rvalid", cpu_rvalid, 1);
            chk("rdata", cpu_dat_r, rq[0].dat);
            void'(rq.pop_front());
        end else chk("rvalid_quiet", cpu_rvalid, 0);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        cpu_req = 1'b0;
        fill_req = 1'b0;
        rq.delete();
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("rst_ack", cpu_ack, 0);
            chk("rst_dat_r", cpu_dat_r, 0);
            chk("rst_grant", fill_grant, 0);
            chk("rst_done", fill_done, 0);
            chk("rst_wren", ram_wren, 0);
            chk("rst_byteena", ram_byteena, 0);
            chk("rst_address", ram_address, 0);
            chk("rst_data", ram_data, 0);
        end
        reset = 1'b0;
        fill_dv = 1'b0;
    endtask

    task automatic cpu_set(input logic we, input logic [BW-1:0] be, input logic [AW-1:0] adr, input logic [DW-1:0] dat);
        cpu_we = we;
        cpu_be = be;
        cpu_adr = adr;
        cpu_dat_w = dat;
        cpu_req = 1'b1;
    endtask

    task automatic cpu_wait(input int exp_wait);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!cpu_ack && n < 40);
        chk("cpu_ack_seen", cpu_ack, 1);
        if (exp_wait > 0) chk("cpu_latency", n, exp_wait);
        chk("cpu_ram_address", ram_address, cpu_adr);
        chk("cpu_ram_wren", ram_wren, cpu_we);
        chk("cpu_ram_byteena", ram_byteena, cpu_we ? 32'(cpu_be) : 32'd0);
        chk("cpu_ram_data", ram_data, cpu_dat_w);
        if (cpu_we) begin
            if (cpu_be[0]) ref_mem[cpu_adr][7:0] = cpu_dat_w[7:0];
            if (cpu_be[1]) ref_mem[cpu_adr][15:8] = cpu_dat_w[15:8];
        end else rq.push_back('{cyc + 2, ref_mem[cpu_adr]});
        cpu_req = 1'b0;
    endtask

    task automatic cpu_op(input logic we, input logic [BW-1:0] be, input logic [AW-1:0] adr, input logic [DW-1:0] dat, input int exp_wait);
        cpu_set(we, be, adr, dat);
        cpu_wait(exp_wait);
    endtask

    // d0 != 0 gives words d0*1..d0*BURST, otherwise random words
    task automatic fill_run(input logic [AW-1:0] adr, input int exp_wait, input int gap, input logic [DW-1:0] d0);
        int n = 0;
        logic [AW-1:0] base;
        logic [DW-1:0] d;
        fill_adr = adr;
        fill_req = 1'b1;
        do begin
            tick();
            n++;
        end while (!fill_grant && n < 40);
        chk("fill_grant_seen", fill_grant, 1);
        chk("fill_grant_no_ack", cpu_ack, 0);
        if (exp_wait > 0) chk("fill_latency", n, exp_wait);
        fill_req = 1'b0;
        fill_adr = AW'($urandom);
        base = adr & ~AW'(BURST - 1);
        for (int i = 0; i < BURST; i++) begin
            for (int g = 0; g < gap; g++) begin
                tick();
                chk("gap_wren", ram_wren, 0);
                chk("gap_grant", fill_grant, 1);
                chk("gap_no_ack", cpu_ack, 0);
            end
            d = d0 != 0 ? d0 * DW'(i + 1) : DW'($urandom);
            fill_dv = 1'b1;
            fill_dat = d;
            tick();
            fill_dv = 1'b0;
            chk("fill_wren", ram_wren, 1);
            chk("fill_address", ram_address, base + AW'(i));
            chk("fill_byteena", ram_byteena, 2'b11);
            chk("fill_data", ram_data, d);
            chk("fill_grant", fill_grant, i < BURST - 1);
            chk("fill_done", fill_done, i == BURST - 1);
            chk("fill_no_ack", cpu_ack, 0);
            ref_mem[base + AW'(i)] = d;
        end
    endtask

    initial begin
        logic [DW-1:0] w0;
        logic [AW-1:0] a;
        for (int i = 0; i < 2**AW; i++) begin
            mem[i] = '0;
            ref_mem[i] = '0;
        end
        do_reset();
        // byte-masked write then read of the same word
        cpu_op(1'b1, 2'b01, 11'h123, 16'hABCD, 1);
        cpu_op(1'b0, 2'b00, 11'h123, 16'h0000, 2);
        chk("be_merge_model", ref_mem[11'h123], 16'h00CD);
        // fill with unaligned base; pending read return overlaps the grant
        fill_run(11'h7F6, 2, 0, 16'h1111);
        tick();
        chk("fill_done_pulse", fill_done, 0);
        cpu_op(1'b0, 2'b00, 11'h7F4, 16'h0, 1);
        for (int i = 5; i < 8; i++) cpu_op(1'b0, 2'b00, 11'h7F0 | AW'(i), 16'h0, 2);
        // ties from reset: CPU first, then fill beats the re-requesting CPU
        do_reset();
        w0 = DW'($urandom);
        cpu_set(1'b1, 2'b11, 11'h050, w0);
        fill_adr = 11'h3A0;
        fill_req = 1'b1;
        cpu_wait(1);
        chk("tie1_no_grant", fill_grant, 0);
        cpu_set(1'b0, 2'b00, 11'h050, 16'h0);
        fill_run(11'h3A0, 2, 2, 16'h0);
        cpu_wait(1);
        // reset after two fill words
        tick();
        fill_run(11'h2C8, 1, 0, 16'h0);
        tick();
        tick();
        tick();
        a = 11'h51C;
        fill_adr = a;
        fill_req = 1'b1;
        tick();
        chk("abort_grant", fill_grant, 1);
        fill_req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            w0 = DW'($urandom);
            fill_dv = 1'b1;
            fill_dat = w0;
            tick();
            chk("abort_wren", ram_wren, 1);
            ref_mem[a + AW'(i)] = w0;
        end
        fill_dat = 16'hDEAD;
        do_reset();
        tick();
        chk("abort_no_wren", ram_wren, 0);
        chk("abort_no_grant", fill_grant, 0);
        chk("abort_no_done", fill_done, 0);
        for (int i = 0; i < BURST; i++) cpu_op(1'b0, 2'b00, a + AW'(i), 16'h0, 0);
        fill_run(a, 0, 0, 16'h0);
        // strobes while idle are ignored
        tick();
        fill_dv = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("idle_dv_wren", ram_wren, 0);
            chk("idle_dv_grant", fill_grant, 0);
        end
        fill_dv = 1'b0;
        cpu_op(1'b0, 2'b00, a, 16'h0, 1);
        cpu_op(1'b0, 2'b00, a + 11'd3, 16'h0, 2);
        // random mixed traffic in a small window, then full readback
        for (int k = 0; k < 30; k++) begin
            a = 11'h7E0 | AW'($urandom_range(0, 31));
            case ($urandom_range(0, 2))
                0: cpu_op(1'b1, BW'($urandom_range(1, 3)), a, DW'($urandom), 0);
                1: cpu_op(1'b0, 2'b00, a, 16'h0, 0);
                default: fill_run(a, 0, $urandom_range(0, 2), 16'h0);
            endcase
        end
        for (int i = 0; i < 32; i++) cpu_op(1'b0, 2'b00, 11'h7E0 | AW'(i), 16'h0, 0);
        for (int k = 0; k < 4; k++) tick();
        chk("reads_drained", rq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dpram_arb_2048x16.md
# dpram_arb_2048x16

Port-A scheduler for the 2048x16 byte-enable dual-port cache RAM in the SDRAM path. It shares the single RAM port between two requesters: CPU single-word reads/writes with byte enables, and an SDRAM line-fill engine that writes fixed-length bursts. Arbitration is round-robin with req/ack handshakes. The block owns every port-A input and returns read data with a fixed, documented latency.

## Interface
- `AW`, 11, RAM word-address width
- `DW`, 16, data width
- `BW`, 2, byte-enable width (`DW/8`)
- `BURST`, 4, words per fill burst (power of two, 2..16)

Ports:
- `clock` in 1: single clock for all logic
- `reset` in 1: synchronous, active-high
- `cpu_req` in 1: CPU access request, held until `cpu_ack`
- `cpu_we` in 1: 1 = write, 0 = read
- `cpu_be` in `BW`: byte enables (writes only)
- `cpu_adr` in `AW`: word address
- `cpu_dat_w` in `DW`: write data
- `cpu_ack` out 1: one-cycle pulse; the access was issued
- `cpu_dat_r` out `DW`: read data, registered
- `cpu_rvalid` out 1: one-cycle pulse; `cpu_dat_r` valid
- `fill_req` in 1: fill request, held until `fill_grant`
- `fill_adr` in `AW`: burst base; low `log2(BURST)` bits ignored, treated as 0
- `fill_dv` in 1: fill word strobe, honoured only while granted
- `fill_dat` in `DW`: fill word
- `fill_grant` out 1: level, high for the whole burst
- `fill_done` out 1: one-cycle pulse after the last word is written
- `ram_wren` out 1: to RAM `wren_a`
- `ram_byteena` out `BW`: to RAM `byteena_a`
- `ram_address` out `AW`: to RAM `address_a`
- `ram_data` out `DW`: to RAM `data_a`
- `ram_q` in `DW`: from RAM `q_a`, 1-cycle registered read

## Operation
- FSM states: `IDLE`, `CPU`, `FILL`.
- `IDLE`:
  - Only `cpu_req` → `CPU`.
  - Only `fill_req` → `FILL`.
  - Both → grant the requester not granted last; `last` resets to fill, so CPU wins first.
- `CPU` lasts 1 cycle, then returns to `IDLE`.
  - Registered outputs drive `ram_address=cpu_adr`, `ram_wren=cpu_we`, `ram_byteena=cpu_be` (forced `2'b00` on reads), `ram_data=cpu_dat_w`.
  - `cpu_ack` is high in this cycle.
- `FILL`:
  - `fill_grant=1` and word counter `cnt=0`.
  - Each `fill_dv` registers a write: `ram_address = {fill_adr[AW-1:log2 BURST], cnt}`, `ram_byteena` all ones, `ram_wren=1`.
  - `cnt` increments per `fill_dv`. Gaps between strobes are allowed, and `ram_wren=0` in gap cycles.
  - After word `BURST-1`: `fill_grant` drops and the FSM returns to `IDLE`. `fill_done` pulses in the first `IDLE` cycle.
  - `fill_adr` is latched at grant. Later changes are ignored.
- CPU requests are stalled (no ack) for the whole burst. No pre-emption.
- `fill_dv` outside `FILL` is ignored.
- Read return: `cpu_dat_r <= ram_q` two cycles after the `CPU` state, with a `cpu_rvalid` pulse. Writes produce no `rvalid`.
- Read return is pipelined and independent of the FSM. A new grant may overlap a pending read return.
- Port B is untouched. Same-address port-A/port-B write collisions are the system's responsibility.

## Timing
- Reset values: state `IDLE`, `last`=fill, `cnt=0`. All outputs are 0: `cpu_ack`, `cpu_rvalid`, `cpu_dat_r`, `fill_grant`, `fill_done`, `ram_*`.
- CPU path, request first seen in `IDLE` at cycle N:
  - N+1: `CPU` state; `ram_*` driven; `cpu_ack=1`.
  - Edge ending N+1: RAM samples.
  - N+2: `ram_q` valid.
  - N+3: `cpu_dat_r` and `cpu_rvalid`.
- Read latency: 3 cycles request→data. Issue throughput: one CPU access every 2 cycles (`IDLE`/`CPU` alternation).
- Fill path, request seen at N:
  - `fill_grant` high from N+1.
  - A `fill_dv` in cycle M (M ≥ N+1) gives `ram_wren` in M+1.
  - Last `fill_dv` at cycle L: `fill_grant` low at L+1, `fill_done` at L+1.
  - Minimum burst occupancy: `BURST+1` cycles.
- `reset` mid-burst: aborts. Writes stop from the next cycle and `cnt` clears. No `fill_done`, no `rvalid` for in-flight reads.
- `cnt` is `log2(BURST)` bits and wraps to 0 after the final word. Addresses never cross a burst-aligned block.

## Structure
- Shared sdram package: `AW`/`DW`/`BW` defaults, `BURST` default, state encoding constants `ST_IDLE`, `ST_CPU`, `ST_FILL`.
- One natural sub-module: `rr_arb2` (2-way round-robin with `last` register, grant on enable).
- The read-return shift register (2 stages of valid plus data capture) stays inline.

## Test plan
- Reset, then CPU write `adr=0x123`, `be=2'b01`, `dat=0xABCD`, then read `0x123` → `ram_wren` with `byteena=01` at N+1; read returns `0x00CD` (upper byte previously 0) with `rvalid` at N+3.
- Fill `fill_adr=0x7F6`, 4 back-to-back `fill_dv` with `0x1111`..`0x4444` → writes to `0x7F4`..`0x7F7`; `fill_done` pulse one cycle after the last strobe; CPU readback matches.
- `cpu_req` and `fill_req` asserted together from reset → CPU granted first, then fill. A second simultaneous pair → fill first (round-robin alternation).
- Fill with 2-cycle gaps between strobes while `cpu_req` is held → no `cpu_ack` until `fill_done`; `ram_wren` low in gap cycles.
- Assert `reset` after the 2nd fill word → no further writes, `fill_grant` and `fill_done` 0. A new fill restarts at `cnt=0`.
- `fill_dv` pulses while `IDLE` → no `ram_wren`. A CPU read issued alongside a pending prior read return → both `rvalid` pulses in order with correct data.
